// File: rtl/if_stage_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, address/instruction
// widths and the default bubble instruction.
package if_stage_pkg;

  localparam int PC_W   = 32;
  localparam int INST_W = 32;

  // Instruction placed in IF/ID whenever it holds no real instruction.
  localparam logic [0:INST_W-1] NOP_INST_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2
  } if_state_e;

endpackage : if_stage_pkg

// File: rtl/if_skid_buf.sv
// One-entry skid buffer for the fetch stage. Holds an instruction that came
// back from memory while ID was stalled, so the response is not lost.
//
// Ports:
//   clk, reset_n         clock, synchronous active-low reset
//   load                 capture load_pc/load_inst, mark entry valid
//   drain                entry consumed by IF/ID this cycle
//   clear                drop the entry (branch redirect); wins over load
//   load_pc, load_inst   data captured on load
//   pc, inst, valid      stored entry
module if_skid_buf
  import if_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              drain,
  input  logic              clear,
  input  logic [0:PC_W-1]   load_pc,
  input  logic [0:INST_W-1] load_inst,
  output logic [0:PC_W-1]   pc,
  output logic [0:INST_W-1] inst,
  output logic              valid
);

  logic [0:PC_W-1]   pc_r;
  logic [0:INST_W-1] inst_r;
  logic              valid_r;

  // Entry storage: clear beats load beats drain.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_r    <= 32'h0000_0000;
      inst_r  <= 32'h0000_0000;
      valid_r <= 1'b0;
    end else if (clear) begin
      valid_r <= 1'b0;
    end else if (load) begin
      pc_r    <= load_pc;
      inst_r  <= load_inst;
      valid_r <= 1'b1;
    end else if (drain) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign pc    = pc_r;
  assign inst  = inst_r;
  assign valid = valid_r;

endmodule : if_skid_buf

// File: rtl/if_stage.sv
// Instruction-fetch stage: drives the instruction-memory request, owns the
// PC, and fills the IF/ID pipeline register. Handles ID stalls through a
// one-entry skid buffer and branch redirects, dropping a response that is
// still in flight when a redirect happens.
//
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   ID_br_ctrl, ID_br_target     taken-branch redirect from ID
//   ID_stall                     ID cannot accept a new instruction
//   imem_req, imem_addr          memory request (address is the PC)
//   imem_ready, imem_inst        memory response
//   IF_ID_pc/inst/valid          IF/ID pipeline register
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [0:PC_W-1]   PC_RESET = 32'h0000_0000,
  parameter logic [0:PC_W-1]   PC_STEP  = 32'd4,
  parameter logic [0:INST_W-1] NOP_INST = NOP_INST_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ID_br_ctrl,
  input  logic [0:31]       ID_br_target,
  input  logic              ID_stall,
  output logic              imem_req,
  output logic [0:31]       imem_addr,
  input  logic              imem_ready,
  input  logic [0:31]       imem_inst,
  output logic [0:31]       IF_ID_pc,
  output logic [0:31]       IF_ID_inst,
  output logic              IF_ID_valid
);

  if_state_e         state_r, state_nxt_s;
  logic [0:PC_W-1]   pc_r, pc_nxt_s;
  logic              req_r, req_nxt_s;
  logic [0:PC_W-1]   ifid_pc_r, ifid_pc_nxt_s;
  logic [0:INST_W-1] ifid_inst_r, ifid_inst_nxt_s;
  logic              ifid_valid_r, ifid_valid_nxt_s;

  logic              redirect_s;
  logic              skid_load_s, skid_drain_s, skid_clear_s;
  logic              skid_valid_nxt_s;
  logic [0:PC_W-1]   skid_pc_s;
  logic [0:INST_W-1] skid_inst_s;
  logic              skid_valid_s;

  // A stalled ID stage has not consumed its branch yet, so it cannot redirect.
  assign redirect_s = ID_br_ctrl & ~ID_stall;

  if_skid_buf u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (skid_load_s),
    .drain     (skid_drain_s),
    .clear     (skid_clear_s),
    .load_pc   (pc_r),
    .load_inst (imem_inst),
    .pc        (skid_pc_s),
    .inst      (skid_inst_s),
    .valid     (skid_valid_s)
  );

  // Next-state, PC, IF/ID and skid-control decode.
  always_comb begin
    state_nxt_s      = state_r;
    pc_nxt_s         = pc_r;
    ifid_pc_nxt_s    = ifid_pc_r;
    ifid_inst_nxt_s  = ifid_inst_r;
    ifid_valid_nxt_s = ifid_valid_r;
    skid_load_s      = 1'b0;
    skid_drain_s     = 1'b0;
    skid_clear_s     = 1'b0;
    skid_valid_nxt_s = skid_valid_s;

    case (state_r)
      IDLE: begin
        state_nxt_s = FETCH;
        pc_nxt_s    = PC_RESET;
      end

      FETCH: begin
        if (redirect_s) begin
          // Anything fetched past the branch is wrong-path: bubble and flush.
          pc_nxt_s         = ID_br_target;
          ifid_inst_nxt_s  = NOP_INST;
          ifid_valid_nxt_s = 1'b0;
          skid_clear_s     = 1'b1;
          skid_valid_nxt_s = 1'b0;
          // An unanswered request will still return; it must be swallowed.
          if (req_r && !imem_ready) begin
            state_nxt_s = DISCARD;
          end else begin
            state_nxt_s = FETCH;
          end
        end else if (skid_valid_s) begin
          // Buffered instruction is older than anything memory could return.
          if (!ID_stall) begin
            ifid_pc_nxt_s    = skid_pc_s;
            ifid_inst_nxt_s  = skid_inst_s;
            ifid_valid_nxt_s = 1'b1;
            skid_drain_s     = 1'b1;
            skid_valid_nxt_s = 1'b0;
          end else begin
            ifid_valid_nxt_s = ifid_valid_r;
          end
        end else if (req_r && imem_ready) begin
          pc_nxt_s = pc_r + PC_STEP;
          if (!ID_stall) begin
            ifid_pc_nxt_s    = pc_r;
            ifid_inst_nxt_s  = imem_inst;
            ifid_valid_nxt_s = 1'b1;
          end else begin
            skid_load_s      = 1'b1;
            skid_valid_nxt_s = 1'b1;
          end
        end else if (!ID_stall) begin
          // ID consumed IF/ID and nothing new arrived.
          ifid_inst_nxt_s  = NOP_INST;
          ifid_valid_nxt_s = 1'b0;
        end else begin
          ifid_valid_nxt_s = ifid_valid_r;
        end
      end

      DISCARD: begin
        if (redirect_s) begin
          pc_nxt_s         = ID_br_target;
          ifid_inst_nxt_s  = NOP_INST;
          ifid_valid_nxt_s = 1'b0;
        end else if (!ID_stall) begin
          ifid_inst_nxt_s  = NOP_INST;
          ifid_valid_nxt_s = 1'b0;
        end else begin
          ifid_valid_nxt_s = ifid_valid_r;
        end
        // The stale response is the only thing that ends DISCARD.
        if (imem_ready) begin
          state_nxt_s = FETCH;
        end else begin
          state_nxt_s = DISCARD;
        end
      end

      default: begin
        state_nxt_s = IDLE;
      end
    endcase

    // Requests stop while the skid buffer holds an undelivered instruction.
    req_nxt_s = (state_nxt_s == FETCH) && !skid_valid_nxt_s;
  end

  // Stage state and output registers; reset dominates redirect and stall.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      pc_r         <= PC_RESET;
      req_r        <= 1'b0;
      ifid_pc_r    <= 32'h0000_0000;
      ifid_inst_r  <= NOP_INST;
      ifid_valid_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      pc_r         <= pc_nxt_s;
      req_r        <= req_nxt_s;
      ifid_pc_r    <= ifid_pc_nxt_s;
      ifid_inst_r  <= ifid_inst_nxt_s;
      ifid_valid_r <= ifid_valid_nxt_s;
    end
  end

  assign imem_req    = req_r;
  assign imem_addr   = pc_r;
  assign IF_ID_pc    = ifid_pc_r;
  assign IF_ID_inst  = ifid_inst_r;
  assign IF_ID_valid = ifid_valid_r;

endmodule : if_stage

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: per-cycle stimulus table with hand-computed
// expected outputs, plus a bounded post-reset request check.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] TAG = 32'hC0DE_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ID_br_ctrl;
  logic [31:0] ID_br_target;
  logic        ID_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_inst;
  logic [31:0] IF_ID_pc;
  logic [31:0] IF_ID_inst;
  logic        IF_ID_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Memory model: data returned is the fetch address tagged with a constant.
  assign imem_inst = imem_addr ^ TAG;

  if_stage #(
    .PC_RESET (32'h0000_0000),
    .PC_STEP  (32'd4),
    .NOP_INST (NOP)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ID_br_ctrl   (ID_br_ctrl),
    .ID_br_target (ID_br_target),
    .ID_stall     (ID_stall),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_inst    (imem_inst),
    .IF_ID_pc     (IF_ID_pc),
    .IF_ID_inst   (IF_ID_inst),
    .IF_ID_valid  (IF_ID_valid)
  );

  typedef struct {
    logic        rst_n;
    logic        br;
    logic [31:0] tgt;
    logic        stall;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst_n, logic br, logic [31:0] tgt,
                              logic stall, logic rdy, logic e_req,
                              logic [31:0] e_addr, logic e_vld,
                              logic [31:0] e_pc);
    vec_t v;
    v.rst_n = rst_n; v.br = br; v.tgt = tgt; v.stall = stall; v.rdy = rdy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic chk(input string name, input int step,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0; ID_br_ctrl = 1'b0; ID_br_target = 32'h0;
    ID_stall = 1'b0; imem_ready = 1'b0;

    //          rst br tgt           st rdy  req addr          vld pc
    // reset state
    vecs.push_back(mk(0, 0, 32'h0,        0, 0,  0, 32'h0,        0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0,  0, 32'h0,        0, 32'h0));
    // IDLE -> FETCH, then back-to-back fetches 0,4,8,C
    vecs.push_back(mk(1, 0, 32'h0,        0, 0,  1, 32'h0,        0, 32'h0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1,  1, 32'h4,        1, 32'h0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1,  1, 32'h8,        1, 32'h4));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1,  1, 32'hC,        1, 32'h8));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1,  1, 32'h10,       1, 32'hC));
    vecs.push_back(mk(1, 0, 32'h0,        0, 0,  1, 32'h10,       0, 32'hC));
    // redirect to 0x100 at PC 0x10 with response same cycle
    vecs.push_back(mk(1, 1, 32'h100,      0, 1,  1, 32'h100,      0, 32'hC));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1,  1, 32'h104,      1, 32'h100));
    // redirect to 0x200 while response outstanding -> DISCARD
    vecs.push_back(mk(1, 0, 32'h0,        0, 0,  1, 32'h104,      0, 32'h100));
    vecs.push_back(mk(1, 1, 32'h200,      0, 0,  0, 32'h200,      0, 32'h100));
    vecs.push_back(mk(1, 0, 32'h0,        0, 0,  0, 32'h200,      0, 32'h100));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1,  1, 32'h200,      0, 32'h100));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1,  1, 32'h204,      1, 32'h200));
    // stall during response -> skid, hold, drain in order
    vecs.push_back(mk(1, 0, 32'h0,        1, 1,  0, 32'h208,      1, 32'h200));
    vecs.push_back(mk(1, 0, 32'h0,        1, 0,  0, 32'h208,      1, 32'h200));
    vecs.push_back(mk(1, 0, 32'h0,        0, 0,  1, 32'h208,      1, 32'h204));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1,  1, 32'h20C,      1, 32'h208));
    // branch under stall ignored, then taken once stall releases
    vecs.push_back(mk(1, 1, 32'h300,      1, 0,  1, 32'h20C,      1, 32'h208));
    vecs.push_back(mk(1, 1, 32'h300,      0, 0,  0, 32'h300,      0, 32'h208));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1,  1, 32'h300,      0, 32'h208));
    // PC wrap at 0xFFFF_FFFC
    vecs.push_back(mk(1, 1, 32'hFFFF_FFF8, 0, 1, 1, 32'hFFFF_FFF8, 0, 32'h208));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1,  1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFF8));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1,  1, 32'h0,        1, 32'hFFFF_FFFC));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1,  1, 32'h4,        1, 32'h0));
    // second redirect in DISCARD: latest target wins
    vecs.push_back(mk(1, 1, 32'h400,      0, 0,  0, 32'h400,      0, 32'h0));
    vecs.push_back(mk(1, 1, 32'h500,      0, 0,  0, 32'h500,      0, 32'h0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1,  1, 32'h500,      0, 32'h0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1,  1, 32'h504,      1, 32'h500));
    // reset overrides branch and stall; stale response after release ignored
    vecs.push_back(mk(0, 1, 32'h700,      1, 1,  0, 32'h0,        0, 32'h0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1,  1, 32'h0,        0, 32'h0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 0,  1, 32'h0,        0, 32'h0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1,  1, 32'h4,        1, 32'h0));

    #1;
    foreach (vecs[i]) begin
      reset_n      = vecs[i].rst_n;
      ID_br_ctrl   = vecs[i].br;
      ID_br_target = vecs[i].tgt;
      ID_stall     = vecs[i].stall;
      imem_ready   = vecs[i].rdy;
      @(posedge clk);
      #1;
      chk("imem_req",    i, {31'd0, imem_req},    {31'd0, vecs[i].e_req});
      chk("imem_addr",   i, imem_addr,            vecs[i].e_addr);
      chk("IF_ID_valid", i, {31'd0, IF_ID_valid}, {31'd0, vecs[i].e_vld});
      chk("IF_ID_pc",    i, IF_ID_pc,             vecs[i].e_pc);
      chk("IF_ID_inst",  i, IF_ID_inst,
          vecs[i].e_vld ? (vecs[i].e_pc ^ TAG) : NOP);
    end

    // Hand sequence: after a fresh reset a request must appear within a
    // bounded number of cycles, at the reset PC, with IF/ID still empty.
    ID_br_ctrl = 1'b0; ID_stall = 1'b0; imem_ready = 1'b0;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    begin
      int waited;
      waited = 0;
      while (!imem_req && waited < 5) begin
        @(posedge clk); #1;
        waited++;
      end
      chk("req_timeout", waited, {31'd0, imem_req}, 32'd1);
      chk("req_addr",    waited, imem_addr, 32'h0000_0000);
      chk("req_ifid",    waited, {31'd0, IF_ID_valid}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_if_stage

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter PC_RESET, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter PC_STEP, default 4: sequential PC increment.
REQ-003 SHALL have parameter NOP_INST, default 32'h0000_0000: instruction injected on bubbles.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 ID_br_ctrl  in  1  taken-branch decision from ID stage (bez/bnez result).
REQ-007 ID_br_target  in  [0:31]  branch target address from ID.
REQ-008 ID_stall  in  1  hazard stall; IF/ID register and PC hold.
REQ-009 imem_req  out  1  instruction-memory request.
REQ-010 imem_addr  out  [0:31]  fetch address; equals PC.
REQ-011 imem_ready  in  1  imem_inst valid this cycle for the outstanding request.
REQ-012 imem_inst  in  [0:31]  fetched instruction.
REQ-013 IF_ID_pc  out  [0:31]  PC of the instruction in the IF/ID register.
REQ-014 IF_ID_inst  out  [0:31]  IF/ID instruction; NOP_INST when invalid.
REQ-015 IF_ID_valid  out  1  IF/ID holds a real instruction.

Function
REQ-016 FSM states SHALL be IDLE, FETCH, DISCARD.
REQ-017 IDLE: entered by reset; next cycle goes to FETCH with PC=PC_RESET; no request in IDLE.
REQ-018 FETCH: imem_req=1, imem_addr=PC, held stable until imem_ready.
REQ-019 A fetch completes only on imem_ready=1 and ID_stall=0; then IF/ID <= {PC, imem_inst, valid=1} and PC <= PC+PC_STEP, modulo 2^32 (0xFFFF_FFFC+4 wraps to 0).
REQ-020 imem_ready=1 with ID_stall=1: instruction SHALL be captured in a one-entry skid buffer, PC advanced, IF/ID held, no new request until the buffer drains.
REQ-021 Skid buffer non-empty and ID_stall=0: IF/ID SHALL load from the buffer before any new memory data; one cycle per entry.
REQ-022 Branch redirect SHALL occur when ID_br_ctrl=1 and ID_stall=0; ID_br_ctrl with ID_stall=1 SHALL be ignored.
REQ-023 On redirect: PC <= ID_br_target, skid buffer cleared, IF/ID loaded with NOP_INST and valid=0 (one bubble), same edge.
REQ-024 Redirect while a request is outstanding (FETCH, no imem_ready that cycle): FSM SHALL enter DISCARD, drop the next imem_ready response, then re-enter FETCH at the target.
REQ-025 Redirect in the same cycle as imem_ready: response dropped, FETCH continues directly at target, no DISCARD.
REQ-026 Second redirect while in DISCARD: latest target SHALL win; DISCARD persists until the old response returns.
REQ-027 Fetch latency: imem_ready at edge N with no stall -> IF_ID_valid=1 after edge N; back-to-back imem_ready SHALL sustain one instruction per cycle.
REQ-028 ID_stall=1 with no pending response: PC, IF/ID, FSM state all SHALL hold.

Reset
REQ-029 reset_n=0 at a rising edge: state=IDLE, PC=PC_RESET, IF_ID_pc=0, IF_ID_inst=NOP_INST, IF_ID_valid=0, imem_req=0, skid buffer empty.
REQ-030 Reset mid-fetch: an outstanding response arriving after reset release SHALL be ignored until the first post-reset request is issued.
REQ-031 Reset SHALL override redirect and stall.

Structure
REQ-032 FSM state encoding, NOP_INST and PC width constant SHALL live in the shared cpu package/include.
REQ-033 Skid buffer SHALL be a sub-module if_skid_buf (one entry: pc, inst, valid; load/drain/clear).

Verification
REQ-034 Reset then imem_ready every cycle returning PC-tagged data -> IF_ID_pc sequence 0,4,8,12; valid from second post-reset edge.
REQ-035 ID_br_ctrl=1, target 0x100, during steady fetch at PC 0x10 -> one IF_ID_valid=0 bubble, next IF_ID_pc=0x100.
REQ-036 Redirect to 0x200 while imem_ready low for 3 cycles -> late response discarded, next imem_addr=0x200, no stale instruction in IF/ID.
REQ-037 ID_stall=1 for 2 cycles as imem_ready pulses -> instruction held in skid buffer, delivered in order when stall drops, none lost or duplicated.
REQ-038 ID_br_ctrl=1 with ID_stall=1 -> no redirect; same branch with stall released next cycle -> redirect.
REQ-039 PC=0xFFFF_FFFC fetch completes -> next imem_addr=0x0000_0000.
